// File: rtl/footsies_pkg.sv
// Shared definitions for the footsies game datapath: round-timer phase
// encodings, BCD digit widths, and the game_fsm state encoding used by the
// renderer and the seven-segment driver.
package footsies_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_W       = 2 * BCD_DIGIT_W;
  localparam int PHASE_W     = 3;

  // Round-timer phases, visible on phase_o.
  typedef enum logic [PHASE_W-1:0] {
    TIMER_IDLE    = 3'd0,
    TIMER_CDOWN   = 3'd1,
    TIMER_CDONE   = 3'd2,
    TIMER_FIGHT   = 3'd3,
    TIMER_EXPIRED = 3'd4,
    TIMER_HOLD    = 3'd5
  } timer_phase_e;

  // game_fsm state encoding shared with the renderer and seven_seg_driver.
  typedef enum logic [1:0] {
    GAME_IDLE      = 2'd0,
    GAME_COUNTDOWN = 2'd1,
    GAME_FIGHT     = 2'd2,
    GAME_OVER      = 2'd3
  } game_state_e;

  // Binary 0..99 to packed two-digit BCD {tens, ones}.
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] ones;
    tens = BCD_DIGIT_W'(v / 10);
    ones = BCD_DIGIT_W'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/round_timer_if.sv
// Purpose: bundles the game_fsm phase enables and the round-timer status
//          outputs between game sequencing and the round timer.
// Modports: master = game_fsm side (drives enables), slave = round_timer.
interface round_timer_if;
  import footsies_pkg::*;

  logic               countdown_en_i;
  logic               fight_en_i;
  logic               gameover_en_i;
  logic [BCD_W-1:0]   time_o;
  logic [PHASE_W-1:0] phase_o;
  logic               countdown_done_o;
  logic               timeout_o;
  logic               warn_o;

  modport master (
    output countdown_en_i, fight_en_i, gameover_en_i,
    input  time_o, phase_o, countdown_done_o, timeout_o, warn_o
  );

  modport slave (
    input  countdown_en_i, fight_en_i, gameover_en_i,
    output time_o, phase_o, countdown_done_o, timeout_o, warn_o
  );

endinterface

// File: rtl/bcd_down_counter.sv
// Purpose: loadable two-digit BCD register with saturating decrement.
// Latency: 1 cycle from clr/load/dec to cnt_o; zero_o is combinational on cnt_o.
// Backpressure: none; priority clr > load > dec, dec at 00 is ignored.
// Ports: clk_i/rst_i (sync active-high), clr_i, load_i + load_val_i, dec_i,
//        cnt_o {tens, ones}, zero_o.
module bcd_down_counter
  import footsies_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [BCD_DIGIT_W-1:0] tens_q, tens_d;
  logic [BCD_DIGIT_W-1:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = '0;
      ones_d = '0;
    end else if (load_i) begin
      tens_d = load_val_i[BCD_W-1:BCD_DIGIT_W];
      ones_d = load_val_i[BCD_DIGIT_W-1:0];
    end else if (dec_i && !zero_o) begin
      if (ones_q != '0) begin
        ones_d = ones_q - 1'b1;
      end else begin
        // Borrow: x0 -> (x-1)9. tens is nonzero here because 00 is excluded.
        ones_d = BCD_DIGIT_W'(9);
        tens_d = tens_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign cnt_o  = {tens_q, ones_q};
  assign zero_o = (tens_q == '0) && (ones_q == '0);

endmodule

// File: rtl/round_timer.sv
// Purpose: pre-fight 3-2-1 countdown and 99->00 BCD fight clock for the display.
// Latency: time_o/flags update 1 cycle after the prescaler wrap or enable change.
// Backpressure: none; level enables, priority gameover > fight > countdown.
// Ports: clk_i, rst_i (sync active-high), tif (round_timer_if.slave: enables in,
//        time_o/phase_o/countdown_done_o/timeout_o/warn_o out).
// Optional: define ROUND_TIMER_WARN_EN for the 2 Hz low-time warning on warn_o.
module round_timer
  import footsies_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNTDOWN_SECS = 3,
  parameter int unsigned FIGHT_SECS     = 99
`ifdef ROUND_TIMER_WARN_EN
  ,
  parameter int unsigned WARN_SECS      = 10
`endif
) (
  input  logic          clk_i,
  input  logic          rst_i,
  round_timer_if.slave  tif
);

  localparam logic [BCD_W-1:0] CDOWN_BCD  = to_bcd(COUNTDOWN_SECS);
  localparam logic [BCD_W-1:0] FIGHT_BCD  = to_bcd(FIGHT_SECS);
  localparam logic [7:0]       PRESC_LAST = 8'(FRAMES_PER_SEC - 1);

  timer_phase_e     state_q, state_d;
  logic [7:0]       presc_q, presc_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             cnt_clr, cnt_load, cnt_dec;
  logic [BCD_W-1:0] cnt_load_val;
  logic [BCD_W-1:0] cnt;
  logic             cnt_zero;
  logic             tick;
  logic             last_sec;

  bcd_down_counter u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign tick     = (presc_q == PRESC_LAST);
  // The decrement taking place this cycle lands on 00.
  assign last_sec = (cnt == 8'h01);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = FIGHT_BCD;
    cnt_dec      = 1'b0;

    unique case (state_q)
      TIMER_IDLE: begin
        presc_d   = '0;
        timeout_d = 1'b0;
        // gameover while idle has nothing to freeze: stay idle at 00.
        if (!tif.gameover_en_i) begin
          if (tif.fight_en_i) begin
            state_d  = TIMER_FIGHT;
            cnt_load = 1'b1;
          end else if (tif.countdown_en_i) begin
            state_d      = TIMER_CDOWN;
            cnt_load     = 1'b1;
            cnt_load_val = CDOWN_BCD;
          end
        end
      end

      TIMER_CDOWN: begin
        if (tif.gameover_en_i) begin
          state_d = TIMER_HOLD;
        end else if (tif.fight_en_i) begin
          // fight outranks countdown: abandon the countdown and start the clock.
          state_d  = TIMER_FIGHT;
          cnt_load = 1'b1;
          presc_d  = '0;
        end else if (tif.countdown_en_i) begin
          presc_d = tick ? 8'd0 : presc_q + 8'd1;
          cnt_dec = tick;
          if (tick && last_sec) begin
            state_d = TIMER_CDONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = TIMER_IDLE;
          cnt_clr = 1'b1;
          presc_d = '0;
        end
      end

      TIMER_CDONE: begin
        if (tif.gameover_en_i) begin
          state_d = TIMER_HOLD;
        end else if (tif.fight_en_i) begin
          state_d  = TIMER_FIGHT;
          cnt_load = 1'b1;
          presc_d  = '0;
        end else if (!tif.countdown_en_i) begin
          state_d = TIMER_IDLE;
          cnt_clr = 1'b1;
        end
      end

      TIMER_FIGHT: begin
        if (tif.gameover_en_i) begin
          state_d = TIMER_HOLD;
        end else if (tif.fight_en_i) begin
          presc_d = tick ? 8'd0 : presc_q + 8'd1;
          cnt_dec = tick;
          if (tick && last_sec) begin
            state_d   = TIMER_EXPIRED;
            timeout_d = 1'b1;
            presc_d   = '0;
          end
        end else begin
          // Leaving the fight phase without game over ends the round.
          state_d   = TIMER_IDLE;
          cnt_clr   = 1'b1;
          presc_d   = '0;
          timeout_d = 1'b0;
        end
      end

      TIMER_EXPIRED: begin
        if (tif.gameover_en_i) begin
          state_d = TIMER_HOLD;
        end else if (!tif.fight_en_i) begin
          state_d   = TIMER_IDLE;
          cnt_clr   = 1'b1;
          timeout_d = 1'b0;
        end
      end

      TIMER_HOLD: begin
        // Time, timeout and prescaler stay frozen until game over drops.
        if (!tif.gameover_en_i) begin
          state_d   = TIMER_IDLE;
          cnt_clr   = 1'b1;
          presc_d   = '0;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d   = TIMER_IDLE;
        cnt_clr   = 1'b1;
        presc_d   = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= TIMER_IDLE;
      presc_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ROUND_TIMER_WARN_EN
  localparam logic [BCD_W-1:0] WARN_BCD  = to_bcd(WARN_SECS);
  // Toggle as the prescaler reaches 0 and FRAMES_PER_SEC/2 for an even blink.
  localparam logic [7:0]       HALF_LAST = 8'(FRAMES_PER_SEC / 2 - 1);

  logic warn_q, warn_d;

  always_comb begin
    warn_d = 1'b0;
    unique case (state_d)
      TIMER_EXPIRED: warn_d = 1'b1;
      TIMER_HOLD:    warn_d = warn_q;
      TIMER_FIGHT: begin
        if ((state_q == TIMER_FIGHT) && (cnt <= WARN_BCD) && !cnt_zero) begin
          warn_d = (tick || (presc_q == HALF_LAST)) ? ~warn_q : warn_q;
        end
      end
      default:       warn_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign tif.warn_o = warn_q;
`else
  assign tif.warn_o = 1'b0;
`endif

  assign tif.time_o           = cnt;
  assign tif.phase_o          = state_q;
  assign tif.countdown_done_o = done_q;
  assign tif.timeout_o        = timeout_q;

endmodule

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: a driver applies directed and random
// enable patterns, a decimal-seconds reference model pushes the expected
// outputs, and a monitor pops and compares them one cycle later.
module tb_round_timer;

  localparam int FPS   = 4;
  localparam int CD    = 3;
  localparam int FIGHT = 12;

  localparam int PH_IDLE = 0, PH_CDOWN = 1, PH_CDONE = 2,
                 PH_FIGHT = 3, PH_EXP = 4, PH_HOLD = 5;

  typedef struct {
    logic [7:0] t;
    logic [2:0] ph;
    logic       done;
    logic       to;
    logic       warn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  round_timer_if tif ();

  round_timer #(
    .FRAMES_PER_SEC (FPS),
    .COUNTDOWN_SECS (CD),
    .FIGHT_SECS     (FIGHT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tif   (tif)
  );

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Reference model: time held as plain decimal seconds.
  int m_ph = PH_IDLE, m_t = 0, m_fr = 0;
  bit m_done = 0, m_to = 0;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  task automatic m_start_fight();
    m_ph = PH_FIGHT; m_t = FIGHT; m_fr = 0; m_to = 0;
  endtask

  task automatic m_go_idle();
    m_ph = PH_IDLE; m_t = 0; m_fr = 0; m_to = 0;
  endtask

  // One elapsed frame while counting; returns 1 when a second has passed.
  function automatic bit m_frame();
    bit sec;
    sec  = (m_fr == FPS - 1);
    m_fr = sec ? 0 : m_fr + 1;
    if (sec && m_t > 0) m_t = m_t - 1;
    return sec;
  endfunction

  task automatic model_step(input bit r, input bit cd, input bit fi, input bit go);
    bit sec;
    m_done = 0;
    if (r) begin
      m_go_idle();
      return;
    end
    case (m_ph)
      PH_IDLE: begin
        if (!go) begin
          if (fi) m_start_fight();
          else if (cd) begin m_ph = PH_CDOWN; m_t = CD; m_fr = 0; end
        end
      end
      PH_CDOWN: begin
        if (go) m_ph = PH_HOLD;
        else if (fi) m_start_fight();
        else if (cd) begin
          sec = m_frame();
          if (sec && m_t == 0) begin m_ph = PH_CDONE; m_done = 1; end
        end else m_go_idle();
      end
      PH_CDONE: begin
        if (go) m_ph = PH_HOLD;
        else if (fi) m_start_fight();
        else if (!cd) m_go_idle();
      end
      PH_FIGHT: begin
        if (go) m_ph = PH_HOLD;
        else if (fi) begin
          sec = m_frame();
          if (sec && m_t == 0) begin m_ph = PH_EXP; m_to = 1; m_fr = 0; end
        end else m_go_idle();
      end
      PH_EXP: begin
        if (go) m_ph = PH_HOLD;
        else if (!fi) m_go_idle();
      end
      default: begin
        if (!go) m_go_idle();
      end
    endcase
  endtask

  // Drive one cycle of inputs away from the edge and queue the response
  // expected after the next rising edge.
  task automatic drive(input bit r, input bit cd, input bit fi, input bit go);
    exp_t e;
    @(posedge clk);
    #2;
    rst                = r;
    tif.countdown_en_i = cd;
    tif.fight_en_i     = fi;
    tif.gameover_en_i  = go;
    model_step(r, cd, fi, go);
    e.t    = bcd(m_t);
    e.ph   = 3'(m_ph);
    e.done = m_done;
    e.to   = m_to;
    e.warn = 1'b0;
    exp_q.push_back(e);
  endtask

  // Hold an input pattern until the model reaches the target phase/time/frame.
  task automatic run_until(input bit cd, input bit fi, input bit go,
                           input int ph, input int t, input int fr, input int budget);
    int n;
    n = 0;
    while (!(m_ph == ph && (t < 0 || m_t == t) && (fr < 0 || m_fr == fr))) begin
      if (n >= budget) begin
        vectors++;
        miscompares++;
        $display("FAIL run_until: phase %0d time %0d not reached in %0d cycles (model phase %0d time %0d)",
                 ph, t, budget, m_ph, m_t);
        return;
      end
      drive(0, cd, fi, go);
      n++;
    end
  endtask

  // Monitor: one comparison per cycle against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    bit   bad;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      bad = (tif.time_o !== e.t) || (tif.phase_o !== e.ph) ||
            (tif.countdown_done_o !== e.done) || (tif.timeout_o !== e.to);
`ifndef ROUND_TIMER_WARN_EN
      bad = bad || (tif.warn_o !== e.warn);
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got time=%h phase=%0d done=%b timeout=%b warn=%b, expected time=%h phase=%0d done=%b timeout=%b warn=%b",
                 cyc, tif.time_o, tif.phase_o, tif.countdown_done_o, tif.timeout_o, tif.warn_o,
                 e.t, e.ph, e.done, e.to, e.warn);
      end
    end
  end

  initial begin
    int r, len;
    bit cd, fi, go, rs;
    tif.countdown_en_i = 1'b0;
    tif.fight_en_i     = 1'b0;
    tif.gameover_en_i  = 1'b0;

    // Reset state.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Countdown 03,02,01,00 with done pulse, then CDONE with countdown held.
    repeat (18) drive(0, 1, 0, 0);

    // Fight from CDONE: 12..00 including the 10->09 borrow, then EXPIRED.
    repeat (56) drive(0, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 0);

    // Game over mid-fight at 07 freezes the clock; release returns to IDLE.
    run_until(0, 1, 0, PH_FIGHT, 7, 0, 100);
    repeat (20) drive(0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 0);

    // Reset coincident with a prescaler wrap mid-fight.
    run_until(0, 1, 0, PH_FIGHT, 3, FPS - 1, 100);
    drive(1, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0);

    // Gameover and fight together from CDONE: HOLD at 00, no fight load.
    run_until(1, 0, 0, PH_CDONE, -1, -1, 40);
    repeat (10) drive(0, 1, 1, 1);
    repeat (2) drive(0, 0, 0, 0);

    // Game over after expiry keeps timeout asserted while held.
    run_until(0, 1, 0, PH_EXP, -1, -1, 80);
    repeat (6) drive(0, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 0);

    // Randomised enable patterns held for random lengths.
    for (int s = 0; s < 80; s++) begin
      r   = $urandom_range(0, 11);
      len = $urandom_range(1, 40);
      rs = 0; cd = 0; fi = 0; go = 0;
      case (r)
        0:       ;
        1, 2:    cd = 1;
        3, 4, 5: fi = 1;
        6:       go = 1;
        7:       begin fi = 1; go = 1; end
        8:       begin cd = 1; fi = 1; end
        9:       begin cd = 1; go = 1; end
        10:      begin rs = 1; len = 1; fi = $urandom_range(0, 1); end
        default: begin cd = $urandom_range(0, 1); fi = $urandom_range(0, 1); go = $urandom_range(0, 1); len = 1; end
      endcase
      for (int k = 0; k < len; k++) drive(rs, cd, fi, go);
    end

    // Let the monitor drain the last expectation.
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Game-rate timer between game_fsm and seven_seg_driver; produces the `timer_count_w` value the display consumes.
- Runs the pre-fight countdown (3-2-1), then a two-digit BCD fight clock (99→00).
- Signals countdown completion and timeout back to game sequencing.
- Freezes the displayed time on game over.

Parameters:
- FRAMES_PER_SEC, 60, logic-clock frames per displayed second; legal range 2..255.
- COUNTDOWN_SECS, 3, countdown start value; legal range 1..9.
- FIGHT_SECS, 99, fight clock start value in decimal; legal range 1..99; loaded as BCD.
- WARN_SECS, 10, low-time warning threshold; used only with the optional feature.

Ports:
- clk_i  in  1  game logic clock (60 Hz frame clock or manual step).
- rst_i  in  1  synchronous, active-high reset.
- countdown_en_i  in  1  level from game_fsm: countdown phase.
- fight_en_i  in  1  level from game_fsm: fight phase.
- gameover_en_i  in  1  level from game_fsm: game-over phase.
- time_o  out  8  BCD time, {tens, ones}, feeds the seven-segment driver.
- phase_o  out  3  timer state: IDLE=0, CDOWN=1, CDONE=2, FIGHT=3, EXPIRED=4, HOLD=5.
- countdown_done_o  out  1  one-cycle pulse when the countdown reaches 0.
- timeout_o  out  1  level; high while the fight clock has expired.
- warn_o  out  1  low-time warning; constant 0 unless ROUND_TIMER_WARN_EN is defined.

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - state=IDLE, time_o=8'h00, prescaler=0.
  - countdown_done_o=0, timeout_o=0, warn_o=0.
  - Reset wins over every other input in the same cycle and aborts any phase mid-operation.
- Enable priority each cycle: gameover_en_i > fight_en_i > countdown_en_i.
- IDLE:
  - countdown_en_i=1 → CDOWN; load time={4'h0, COUNTDOWN_SECS}, prescaler=0.
  - fight_en_i=1 → FIGHT directly; load FIGHT_SECS as BCD, prescaler=0.
  - Otherwise hold time_o=8'h00.
- Prescaler:
  - Counts 0..FRAMES_PER_SEC-1, only in CDOWN and FIGHT.
  - A "second" occurs on the cycle prescaler==FRAMES_PER_SEC-1; the prescaler wraps to 0 and time decrements.
  - time_o shows the new value on the following cycle, i.e. 1-cycle registered latency.
- BCD decrement (2 digits):
  - ones≠0 → ones-1.
  - ones=0 → ones=9, tens-1.
  - 00 is never decremented; the time saturates at 00.
- CDOWN:
  - Decrement each second.
  - Decrement to 00 → next state CDONE; countdown_done_o=1 for exactly that first cycle showing 00.
- CDONE:
  - Hold 00.
  - fight_en_i=1 → FIGHT; load FIGHT_SECS, prescaler=0.
- FIGHT:
  - Decrement each second.
  - Decrement to 00 → EXPIRED; timeout_o rises in the same cycle time_o shows 00.
- EXPIRED:
  - timeout_o=1 and time_o=00 held while fight_en_i=1.
  - fight_en_i=0 with no gameover_en_i → IDLE.
- HOLD:
  - Entered from any non-IDLE state when gameover_en_i=1.
  - time_o frozen at its current value; timeout_o keeps its value; prescaler stops.
  - Exit to IDLE when gameover_en_i=0.
- All enables low in CDOWN, CDONE or FIGHT → IDLE, time cleared, timeout_o cleared.
- countdown_en_i held in CDONE: no reload. The countdown runs only once per IDLE→CDOWN entry.
- countdown_done_o never asserts outside the CDOWN→CDONE transition.
- timeout_o is 0 in every state except EXPIRED and a HOLD entered from EXPIRED.

Optional Feature:
- Macro: ROUND_TIMER_WARN_EN.
- Defined:
  - In FIGHT with time ≤ WARN_SECS (BCD compare) and time ≠ 00, warn_o toggles on every prescaler wrap and on prescaler==FRAMES_PER_SEC/2 (2 Hz blink).
  - warn_o=1 steady in EXPIRED.
  - warn_o=0 in all other states; HOLD freezes its value.
- Undefined: warn_o tied to 0; no extra flops.

Decomposition:
- Shared package footsies_pkg:
  - phase encodings (TIMER_IDLE..TIMER_HOLD);
  - BCD digit width constant;
  - the game_fsm state encoding, so the renderer and seven-seg use the same values.
- One natural sub-module: bcd_down_counter.
  - Loadable 2-digit BCD register.
  - Decrement-enable, saturate-at-zero, zero flag.

Test Plan:
1. FRAMES_PER_SEC=4; reset, countdown_en_i=1 → time_o 03,02,01,00 at 4-cycle spacing; countdown_done_o exactly 1 cycle, coincident with first 00; phase_o=2.
2. From CDONE, fight_en_i=1 with FIGHT_SECS=12 → time_o 12,11,10,09,…,00; 10→09 BCD borrow correct; timeout_o rises with 00; phase_o=4.
3. FIGHT at time 57, gameover_en_i=1 → time_o stays 57, prescaler stopped for 20 cycles; gameover_en_i=0 → IDLE, time_o=00.
4. rst_i=1 mid-FIGHT at time 33, concurrent with a prescaler wrap → next cycle time_o=00, phase_o=0, all flags 0.
5. gameover_en_i and fight_en_i both high from CDONE → HOLD, time_o stays 00, no FIGHT load.
6. ROUND_TIMER_WARN_EN defined, WARN_SECS=10, FRAMES_PER_SEC=4: time 11 → warn_o=0; time ≤10 → warn_o toggles every 2 cycles; EXPIRED → warn_o=1 steady.
